// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-RAM arbiter slice.
// Frame geometry, bus widths and the per-cycle RAM grant encoding.
package vga_pkg;

    localparam int PIXELS = 307200;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/vga_write_fifo.sv
// Small synchronous FIFO holding pending pixel writes until the RAM is free.
// The caller guarantees push only when !full and pop only when !empty.
module vga_write_fifo
    import vga_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  wr_entry_t        push_entry,
    input  logic             pop,
    output wr_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; level gates every read, so stale entries are never observed.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/vga_frame_arbiter.sv
// Arbitrates the single-port frame RAM: scan-out reads always win, buffered
// pixel writes drain only on cycles without a scan request.
module vga_frame_arbiter
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        frame_start,
    input  logic                        scan_req,
    output logic [DATA_W-1:0]           pixel_data,
    output logic                        pixel_valid,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [ADDR_W-1:0]           ram_address,
    output logic [DATA_W-1:0]           ram_data,
    output logic                        ram_wren,
    input  logic [DATA_W-1:0]           ram_q,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        addr_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    grant_t            state;
    grant_t            next_state;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] grant_addr;
    logic              wr_fire;
    logic              addr_ok;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    wr_entry_t         fifo_head;

    // Out-of-range writes still complete the handshake so the writer never stalls on them.
    assign wr_ready   = !fifo_full;
    assign wr_fire    = wr_valid && wr_ready;
    assign addr_ok    = (wr_addr < ADDR_W'(PIXELS));
    assign fifo_push  = wr_fire && addr_ok;
    assign fifo_pop   = (next_state == WRITE);
    assign grant_addr = frame_start ? '0 : scan_addr;

    vga_write_fifo #(.DEPTH(FIFO_DEPTH)) u_write_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry ('{addr: wr_addr, data: wr_data}),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    // NOTE: next_state gets its default before any branch so no path can infer a latch.
    always_comb begin
        next_state = IDLE;
        if (scan_req)         next_state = READ;
        else if (!fifo_empty) next_state = WRITE;
    end

    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            scan_addr <= '0;
        end else begin
            state <= next_state;
            if (scan_req)         scan_addr <= (grant_addr == LAST_ADDR) ? '0 : grant_addr + ADDR_W'(1);
            else if (frame_start) scan_addr <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
        end else begin
            case (next_state)
                READ: begin
                    ram_address <= grant_addr;
                    ram_wren    <= 1'b0;
                end
                WRITE: begin
                    ram_address <= fifo_head.addr;
                    ram_data    <= fifo_head.data;
                    ram_wren    <= 1'b1;
                end
                default: ram_wren <= 1'b0;
            endcase
        end
    end

    // Return path: the cycle ram_address carries a read, ram_q is captured alongside pixel_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
            addr_err    <= 1'b0;
        end else begin
            pixel_valid <= (state == READ);
            if (state == READ) pixel_data <= ram_q;
            if (wr_fire && !addr_ok) addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Scoreboard bench for vga_frame_arbiter: stimulus queues expected reads/writes,
// a negedge monitor pops and compares whenever the DUT presents pixel_valid or ram_wren.
module tb_vga_frame_arbiter;
    import vga_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              frame_start;
    logic              scan_req;
    logic [DATA_W-1:0] pixel_data;
    logic              pixel_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic [2:0]        fifo_level;
    logic              addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0]        rd_q [$];
    logic [ADDR_W+DATA_W-1:0] wr_q [$];
    logic [ADDR_W-1:0]        exp_scan;
    logic [ADDR_W-1:0]        mon_addr;
    logic [ADDR_W+DATA_W-1:0] mon_wr;

    always #20 clock = ~clock;

    vga_frame_arbiter #(.FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .scan_req    (scan_req),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .fifo_level  (fifo_level),
        .addr_err    (addr_err)
    );

    // RAM stand-in: ram_q holds the word for the address presented this cycle.
    function automatic logic [DATA_W-1:0] ram_model(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
    endfunction

    assign ram_q = ram_model(ram_address);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic scan_cycle(input logic fs);
        logic [ADDR_W-1:0] a;
        scan_req    = 1'b1;
        frame_start = fs;
        a = fs ? '0 : exp_scan;
        rd_q.push_back(a);
        exp_scan = (a == ADDR_W'(PIXELS - 1)) ? '0 : a + ADDR_W'(1);
        tick();
        frame_start = 1'b0;
    endtask

    task automatic load_scan_addr(input logic [ADDR_W-1:0] a);
        @(negedge clock);
        force dut.scan_addr = a;
        #2;
        release dut.scan_addr;
        exp_scan = a;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_data",    ram_data,    0);
        check("rst_ram_wren",    ram_wren,    0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_data",  pixel_data,  0);
        check("rst_wr_ready",    wr_ready,    1);
        check("rst_fifo_level",  fifo_level,  0);
        check("rst_addr_err",    addr_err,    0);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (pixel_valid) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pixel_unexpected: pixel_valid with data 0x%0h, expected no pixel", pixel_data);
                end else begin
                    mon_addr = rd_q.pop_front();
                    check("pixel_data", pixel_data, ram_model(mon_addr));
                end
            end
            if (ram_wren) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL write_unexpected: ram write addr %0d data 0x%0h, expected none", ram_address, ram_data);
                end else begin
                    mon_wr = wr_q.pop_front();
                    check("ram_write", {ram_address, ram_data}, mon_wr);
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        frame_start = 1'b0;
        scan_req    = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        exp_scan    = '0;

        // Reset state, then three scans: addresses 0,1,2, pixel_valid two cycles after each.
        @(negedge clock);
        check_reset_values();
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            scan_cycle(1'b0);
            check("scan_ram_address", ram_address, i);
            check("scan_ram_wren",    ram_wren,    0);
            check("scan_pixel_valid", pixel_valid, (i >= 1) ? 1 : 0);
        end
        scan_req = 1'b0;
        tick();
        check("scan_pixel_valid_tail", pixel_valid, 1);
        tick();
        check("scan_pixel_valid_done", pixel_valid, 0);

        // Wrap at the last pixel.
        load_scan_addr(19'd307199);
        scan_cycle(1'b0);
        check("wrap_last", ram_address, 307199);
        scan_cycle(1'b0);
        check("wrap_zero", ram_address, 0);
        scan_req = 1'b0;
        tick();
        tick();

        // frame_start with scan_req, then frame_start alone.
        load_scan_addr(19'd1000);
        scan_cycle(1'b1);
        check("fs_scan_zero", ram_address, 0);
        scan_cycle(1'b0);
        check("fs_scan_one", ram_address, 1);
        scan_req = 1'b0;
        tick();
        tick();
        load_scan_addr(19'd500);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_scan = '0;
        scan_cycle(1'b0);
        check("fs_alone_zero", ram_address, 0);
        scan_req = 1'b0;
        tick();
        tick();

        // Five writes under continuous scan: four fit, fifth waits; nothing reaches the RAM.
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(10 + i);
            wr_data  = DATA_W'(8'hA0 + i);
            check("fill_wr_ready", wr_ready, 1);
            wr_q.push_back({wr_addr, wr_data});
            scan_cycle(1'b0);
            check("fill_level", fifo_level, i + 1);
            check("fill_no_wren", ram_wren, 0);
        end
        wr_addr = 19'd14;
        wr_data = 8'hA4;
        check("full_wr_ready", wr_ready, 0);
        scan_cycle(1'b0);
        check("full_level", fifo_level, 4);
        check("full_no_wren", ram_wren, 0);
        scan_req = 1'b0;
        tick();
        check("drain1_level", fifo_level, 3);
        check("drain1_wr_ready", wr_ready, 1);
        wr_q.push_back({wr_addr, wr_data});
        tick();
        wr_valid = 1'b0;
        check("drain2_level", fifo_level, 3);
        tick();
        check("drain3_level", fifo_level, 2);
        tick();
        check("drain4_level", fifo_level, 1);
        tick();
        check("drain5_level", fifo_level, 0);
        tick();
        check("drain_idle_wren", ram_wren, 0);

        // Out-of-range write: handshake completes, not stored, sticky error.
        wr_valid = 1'b1;
        wr_addr  = 19'd307200;
        wr_data  = 8'h55;
        check("oob_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        check("oob_level", fifo_level, 0);
        check("oob_addr_err", addr_err, 1);
        tick();
        tick();
        check("oob_addr_err_sticky", addr_err, 1);

        // Reset during a drain with three entries still queued.
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(100 + i);
            wr_data  = DATA_W'(8'hC0 + i);
            wr_q.push_back({wr_addr, wr_data});
            scan_cycle(1'b0);
        end
        wr_valid = 1'b0;
        scan_req = 1'b0;
        tick();
        check("middrain_level", fifo_level, 3);
        @(negedge clock);
        #5;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        rd_q.delete();
        wr_q.delete();
        exp_scan = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_level", fifo_level, 0);
        check("post_rst_wren", ram_wren, 0);
        check("post_rst_wr_ready", wr_ready, 1);
        check("post_rst_addr_err", addr_err, 0);

        check("pending_reads", rd_q.size(), 0);
        check("pending_writes", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
